// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration sequencer: register map, counter-word
// field positions, FSM state encoding and the stored divider profile words.
package pll_reconfig_pkg;

   localparam logic [5:0] ADDR_MODE   = 6'd0;
   localparam logic [5:0] ADDR_STATUS = 6'd1;
   localparam logic [5:0] ADDR_START  = 6'd2;
   localparam logic [5:0] ADDR_M      = 6'd4;
   localparam logic [5:0] ADDR_C      = 6'd5;
   localparam logic [5:0] ADDR_K      = 6'd7;

   localparam int LO_LSB     = 0;
   localparam int HI_LSB     = 8;
   localparam int BYPASS_BIT = 16;
   localparam int ODD_BIT    = 17;
   localparam int CIDX_LSB   = 18;

   localparam int PROFILE_ENTRIES = 6;

   typedef enum logic [2:0] {
      ST_IDLE, ST_MODE, ST_WR, ST_RDBK, ST_START, ST_POLL, ST_LOCK, ST_ERR
   } state_t;

   function automatic logic [31:0] cnt_word(input logic [7:0] hi, input logic [7:0] lo,
                                            input logic odd, input logic [4:0] cidx);
      logic [31:0] w;
      w = '0;
      w[LO_LSB +: 8]   = lo;
      w[HI_LSB +: 8]   = hi;
      w[BYPASS_BIT]    = 1'b0;
      w[ODD_BIT]       = odd;
      w[CIDX_LSB +: 5] = cidx;
      return w;
   endfunction

   // Profile 0 is stock 6 MHz timing; profile 1 only retunes C1/C2 to 7 MHz.
   localparam logic [31:0] M_WORD  = cnt_word(8'd5, 8'd4, 1'b1, 5'd0);
   localparam logic [31:0] K_WORD  = 32'd216917482;
   localparam logic [31:0] C0_WORD = cnt_word(8'd4, 8'd3, 1'b1, 5'd0);
   localparam logic [31:0] C1_P0   = cnt_word(8'd56, 8'd56, 1'b0, 5'd1);
   localparam logic [31:0] C2_P0   = cnt_word(8'd56, 8'd56, 1'b0, 5'd2);
   localparam logic [31:0] C1_P1   = cnt_word(8'd48, 8'd48, 1'b0, 5'd1);
   localparam logic [31:0] C2_P1   = cnt_word(8'd48, 8'd48, 1'b0, 5'd2);
   localparam logic [31:0] C3_WORD = cnt_word(8'd42, 8'd42, 1'b0, 5'd3);

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the sequencer (master) and the PLL reconfig core (slave).
interface pll_reconfig_seq_if;
   // Handshake: a strobe (write or read) is held with stable address/data until a cycle
   // where waitrequest is low; that cycle completes the transfer and captures readdata.
   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic        mgmt_read;
   logic [31:0] mgmt_writedata;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;

   modport master (output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
                   input  mgmt_readdata, mgmt_waitrequest);
   modport slave  (input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
                   output mgmt_readdata, mgmt_waitrequest);
endinterface

// File: rtl/pll_profile_rom.sv
// Combinational profile table: (profile, index) -> {register address, data word}.
module pll_profile_rom
   import pll_reconfig_pkg::*;
(
   input  logic        profile,
   input  logic [2:0]  index,
   output logic [5:0]  address,
   output logic [31:0] data,
   output logic        last
);

   always_comb begin
      address = ADDR_C;
      data    = '0;
      case (index)
         3'd0: begin address = ADDR_M; data = M_WORD;  end
         3'd1: begin address = ADDR_K; data = K_WORD;  end
         3'd2: data = C0_WORD;
         3'd3: data = profile ? C1_P1 : C1_P0;
         3'd4: data = profile ? C2_P1 : C2_P0;
         3'd5: data = C3_WORD;
         default: begin address = ADDR_M; data = '0; end
      endcase
   end

   assign last = (index == 3'(PROFILE_ENTRIES - 1));

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes a stored divider profile through the reconfig core,
// waits for relock and holds the core in reset meanwhile. Option: PLL_RECONFIG_READBACK_EN.
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_PROFILES = 2,
   parameter int LOCK_TIMEOUT = 1048576,
   parameter int POLL_LIMIT   = 65535
) (
   input  logic   clk_sys,
   input  logic   reset_n,
   input  logic   req,
   input  logic   profile_sel,
   output logic   busy,
   output logic   done,
   output logic   error,
   output logic   active_profile,
   output logic   core_hold,
   pll_reconfig_seq_if.master mgmt,
   input  logic   pll_locked,
   output state_t dbg_state
);

   localparam int LCW = $clog2(LOCK_TIMEOUT + 1);
   localparam int PCW = $clog2(POLL_LIMIT + 1);

   state_t      state;
   logic        prof;
   logic [2:0]  idx;
   logic [LCW-1:0] lock_cnt;
   logic [PCW-1:0] poll_cnt;
   logic [3:0]  stable_cnt;
   logic        locked_meta, locked_s;
   logic [5:0]  rom_addr;
   logic [31:0] rom_data;
   logic        rom_last;
   logic        strobe, xfer_done;
   logic        unused_rd;

   pll_profile_rom u_rom (
      .profile (prof),
      .index   (idx),
      .address (rom_addr),
      .data    (rom_data),
      .last    (rom_last)
   );

   assign strobe    = mgmt.mgmt_write | mgmt.mgmt_read;
   assign xfer_done = strobe & ~mgmt.mgmt_waitrequest;
   assign dbg_state = state;
   assign unused_rd = ^mgmt.mgmt_readdata[31:1];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         locked_meta <= pll_locked;
         locked_s    <= locked_meta;
      end
   end

   // A new strobe is only issued from a cycle where no strobe is up, which leaves the
   // mandatory idle cycle after every completed transfer.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state               <= ST_IDLE;
         prof                <= 1'b0;
         idx                 <= '0;
         lock_cnt            <= '0;
         poll_cnt            <= '0;
         stable_cnt          <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         error               <= 1'b0;
         active_profile      <= 1'b0;
         core_hold           <= 1'b0;
         mgmt.mgmt_address   <= '0;
         mgmt.mgmt_writedata <= '0;
         mgmt.mgmt_write     <= 1'b0;
         mgmt.mgmt_read      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (xfer_done) begin
            mgmt.mgmt_write <= 1'b0;
            mgmt.mgmt_read  <= 1'b0;
         end
         if ((state == ST_POLL || state == ST_LOCK) && lock_cnt != LCW'(LOCK_TIMEOUT))
            lock_cnt <= lock_cnt + 1'b1;

         case (state)
            ST_IDLE: if (req) begin
               prof      <= (NUM_PROFILES > 1) ? profile_sel : 1'b0;
               busy      <= 1'b1;
               core_hold <= 1'b1;
               error     <= 1'b0;
               idx       <= '0;
               state     <= ST_MODE;
            end
            ST_MODE: if (!strobe) begin
               mgmt.mgmt_address   <= ADDR_MODE;
               mgmt.mgmt_writedata <= 32'd1;
               mgmt.mgmt_write     <= 1'b1;
            end else if (xfer_done) state <= ST_WR;
            ST_WR: if (!strobe) begin
               mgmt.mgmt_address   <= rom_addr;
               mgmt.mgmt_writedata <= rom_data;
               mgmt.mgmt_write     <= 1'b1;
            end else if (xfer_done) begin
`ifdef PLL_RECONFIG_READBACK_EN
               state <= ST_RDBK;
`else
               if (rom_last) begin
                  idx   <= '0;
                  state <= ST_START;
               end else idx <= idx + 3'd1;
`endif
            end
`ifdef PLL_RECONFIG_READBACK_EN
            ST_RDBK: if (!strobe) begin
               mgmt.mgmt_address <= rom_addr;
               mgmt.mgmt_read    <= 1'b1;
            end else if (xfer_done) begin
               if (mgmt.mgmt_readdata[22:0] != rom_data[22:0]) state <= ST_ERR;
               else if (rom_last) begin
                  idx   <= '0;
                  state <= ST_START;
               end else begin
                  idx   <= idx + 3'd1;
                  state <= ST_WR;
               end
            end
`endif
            ST_START: if (!strobe) begin
               mgmt.mgmt_address   <= ADDR_START;
               mgmt.mgmt_writedata <= 32'd0;
               mgmt.mgmt_write     <= 1'b1;
            end else if (xfer_done) begin
               lock_cnt <= '0;
               poll_cnt <= '0;
               state    <= ST_POLL;
            end
            ST_POLL: if (!strobe) begin
               mgmt.mgmt_address <= ADDR_STATUS;
               mgmt.mgmt_read    <= 1'b1;
            end else if (xfer_done) begin
               poll_cnt <= poll_cnt + 1'b1;
               if (mgmt.mgmt_readdata[0]) begin
                  stable_cnt <= '0;
                  state      <= ST_LOCK;
               end else if (poll_cnt == PCW'(POLL_LIMIT - 1)) state <= ST_ERR;
            end
            ST_LOCK: begin
               // Relock counts only after 16 consecutive synchronised locked cycles.
               if (locked_s && stable_cnt == 4'd15) begin
                  done           <= 1'b1;
                  busy           <= 1'b0;
                  core_hold      <= 1'b0;
                  active_profile <= prof;
                  state          <= ST_IDLE;
               end else if (lock_cnt == LCW'(LOCK_TIMEOUT)) state <= ST_ERR;
               else stable_cnt <= locked_s ? stable_cnt + 4'd1 : 4'd0;
            end
            ST_ERR: begin
               error     <= 1'b1;
               busy      <= 1'b0;
               core_hold <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: an Avalon responder doubles as bus monitor and pops the
// expected transfer queue on every completed transfer; stimulus runs directed scenarios.
module tb_pll_reconfig_seq;
   import pll_reconfig_pkg::*;

   localparam int LT = 600;
   localparam int PL = 20;

   logic   clk_sys = 1'b0, reset_n = 1'b0, req = 1'b0, profile_sel = 1'b0, pll_locked = 1'b0;
   logic   busy, done, error, active_profile, core_hold;
   state_t dbg_state;

   pll_reconfig_seq_if mgmt ();

   pll_reconfig_seq #(.NUM_PROFILES(2), .LOCK_TIMEOUT(LT), .POLL_LIMIT(PL)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .req            (req),
      .profile_sel    (profile_sel),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .active_profile (active_profile),
      .core_hold      (core_hold),
      .mgmt           (mgmt),
      .pll_locked     (pll_locked),
      .dbg_state      (dbg_state)
   );

   // Clock
   always #5 clk_sys = ~clk_sys;

   // Scoreboard state: {read, address, data(0 for reads)}
   logic [38:0] exp_q[$];
   int n_vec = 0, n_fail = 0;
   int polls_to_done = 0, lock_delay = -1, lock_timer = -1, stall_k = 0;
   int poll_seen = 0, stall_seen = 0, stable_bad = 0, done_cnt = 0, hold_bad = 0, rb5 = 0;
   int cyc = 0, start_cyc = 0, err_cyc = 0;
   bit corrupt_c1 = 1'b0, err_prev = 1'b0;
   logic [31:0] last_wdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] tbl_addr(input int i);
      case (i)
         0: return 6'd4;
         1: return 6'd7;
         default: return 6'd5;
      endcase
   endfunction

   function automatic logic [31:0] tbl_data(input bit p, input int i);
      case (i)
         0: return 32'h0002_0504;
         1: return 32'd216917482;
         2: return 32'h0002_0403;
         3: return p ? 32'h0004_3030 : 32'h0004_3838;
         4: return p ? 32'h0008_3030 : 32'h0008_3838;
         default: return 32'h000C_2A2A;
      endcase
   endfunction

   task automatic push_seq(input bit p, input int n_entries, input bit with_start, input int n_polls);
      exp_q.push_back({1'b0, 6'd0, 32'd1});
      for (int i = 0; i < n_entries; i++) begin
         exp_q.push_back({1'b0, tbl_addr(i), tbl_data(p, i)});
`ifdef PLL_RECONFIG_READBACK_EN
         exp_q.push_back({1'b1, tbl_addr(i), 32'd0});
`endif
      end
      if (with_start) exp_q.push_back({1'b0, 6'd2, 32'd0});
      for (int i = 0; i < n_polls; i++) exp_q.push_back({1'b1, 6'd1, 32'd0});
   endtask

   // Responder + monitor
   initial begin
      logic        in_xfer;
      logic [5:0]  cap_a;
      logic [31:0] cap_d;
      int          stall_left;
      logic [38:0] act, exp;
      in_xfer = 1'b0;
      stall_left = 0;
      mgmt.mgmt_waitrequest = 1'b0;
      mgmt.mgmt_readdata = '0;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (done) done_cnt++;
         if (core_hold !== busy) hold_bad++;
         if (error && !err_prev) err_cyc = cyc;
         err_prev = error;
         if (lock_timer > 0) begin
            lock_timer--;
            if (lock_timer == 0) pll_locked = 1'b1;
         end
         if (reset_n && (mgmt.mgmt_write || mgmt.mgmt_read)) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               cap_a = mgmt.mgmt_address;
               cap_d = mgmt.mgmt_writedata;
               stall_left = (mgmt.mgmt_write && mgmt.mgmt_address == 6'd7) ? stall_k : 0;
            end else if (mgmt.mgmt_address != cap_a ||
                         (mgmt.mgmt_write && mgmt.mgmt_writedata != cap_d)) stable_bad++;
            if (stall_left > 0) begin
               mgmt.mgmt_waitrequest = 1'b1;
               stall_left--;
               stall_seen++;
            end else begin
               mgmt.mgmt_waitrequest = 1'b0;
               in_xfer = 1'b0;
               mgmt.mgmt_readdata = '0;
               if (mgmt.mgmt_read) begin
                  if (mgmt.mgmt_address == 6'd1) begin
                     poll_seen++;
                     mgmt.mgmt_readdata = (polls_to_done != 0 && poll_seen >= polls_to_done) ? 32'd1 : 32'd0;
                  end else begin
                     mgmt.mgmt_readdata = last_wdata;
                     if (mgmt.mgmt_address == 6'd5) begin
                        rb5++;
                        if (corrupt_c1 && rb5 == 2) mgmt.mgmt_readdata = last_wdata ^ 32'h0000_0100;
                     end
                  end
               end else begin
                  last_wdata = mgmt.mgmt_writedata;
                  if (mgmt.mgmt_address == 6'd2) begin
                     pll_locked = 1'b0;
                     lock_timer = lock_delay;
                     start_cyc = cyc;
                  end
               end
               act = {mgmt.mgmt_read, mgmt.mgmt_address, mgmt.mgmt_read ? 32'd0 : mgmt.mgmt_writedata};
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL bus_xfer: got 0x%0h, none expected", act);
               end else begin
                  exp = exp_q.pop_front();
                  if (act !== exp) begin
                     n_fail++;
                     $display("FAIL bus_xfer: got 0x%0h expected 0x%0h", act, exp);
                  end
               end
            end
         end else begin
            in_xfer = 1'b0;
            mgmt.mgmt_waitrequest = 1'b0;
         end
      end
   end

   // Driver tasks
   task automatic pulse_req(input bit p);
      @(negedge clk_sys); #1;
      req = 1'b1;
      profile_sel = p;
      @(negedge clk_sys); #1;
      req = 1'b0;
   endtask

   task automatic start_seq(input bit p, input int polls, input int ldelay, input int stall,
                            input int n_entries, input bit with_start, input int n_polls);
      polls_to_done = polls; lock_delay = ldelay; stall_k = stall;
      poll_seen = 0; stall_seen = 0; stable_bad = 0; done_cnt = 0; hold_bad = 0; rb5 = 0;
      push_seq(p, n_entries, with_start, n_polls);
      pulse_req(p);
      check("busy_on_req", busy, 1);
      check("error_clr_on_req", error, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check("idle_reached", busy, 0);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic wait_state(input state_t s, input string name);
      int n = 0;
      while (dbg_state != s && n < 500) begin
         @(negedge clk_sys);
         n++;
      end
      check(name, dbg_state, s);
   endtask

   initial begin
      // Reset
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_active", active_profile, 0);
      check("rst_hold", core_hold, 0);
      check("rst_strobes", {mgmt.mgmt_write, mgmt.mgmt_read}, 0);
      check("rst_addr", mgmt.mgmt_address, 0);
      check("rst_wdata", mgmt.mgmt_writedata, 0);
      #1 reset_n = 1'b1;

      // Profile 1, done on third poll, lock 200 cycles after start
      start_seq(1, 3, 200, 0, 6, 1, 3);
      wait_idle();
      check("t1_done_pulses", done_cnt, 1);
      check("t1_active", active_profile, 1);
      check("t1_error", error, 0);
      check("t1_hold_vs_busy", hold_bad, 0);
      check("t1_polls", poll_seen, 3);
      check("t1_q_empty", exp_q.size(), 0);

      // Waitrequest stall on the K write
      start_seq(0, 2, 50, 5, 6, 1, 2);
      wait_idle();
      check("t2_stall_cycles", stall_seen, 5);
      check("t2_stable", stable_bad, 0);
      check("t2_active", active_profile, 0);
      check("t2_done_pulses", done_cnt, 1);
      check("t2_q_empty", exp_q.size(), 0);

      // Status never done
      start_seq(1, 0, -1, 0, 6, 1, PL);
      wait_idle();
      check("t3_error", error, 1);
      check("t3_polls", poll_seen, PL);
      check("t3_active", active_profile, 0);
      check("t3_done_pulses", done_cnt, 0);
      check("t3_hold_vs_busy", hold_bad, 0);
      check("t3_q_empty", exp_q.size(), 0);

      // Status done but never locked
      start_seq(1, 1, -1, 0, 6, 1, 1);
      wait_idle();
      check("t4_error", error, 1);
      check("t4_active", active_profile, 0);
      check("t4_timeout_window", (err_cyc - start_cyc >= LT) && (err_cyc - start_cyc <= LT + 8), 1);
      check("t4_q_empty", exp_q.size(), 0);

      // Fresh request after the error runs a full sequence
      start_seq(1, 2, 30, 0, 6, 1, 2);
      wait_idle();
      check("t5_error", error, 0);
      check("t5_active", active_profile, 1);
      check("t5_done_pulses", done_cnt, 1);
      check("t5_q_empty", exp_q.size(), 0);

      // Requests during WR are ignored
      start_seq(0, 1, 40, 0, 6, 1, 1);
      wait_state(ST_WR, "t6_reach_wr");
      pulse_req(1);
      pulse_req(1);
      wait_idle();
      check("t6_active", active_profile, 0);
      check("t6_done_pulses", done_cnt, 1);
      check("t6_q_empty", exp_q.size(), 0);

      // Asynchronous reset in the middle of polling
      start_seq(1, 0, -1, 0, 6, 1, PL);
      wait_state(ST_POLL, "t7_reach_poll");
      @(posedge clk_sys); #3;
      reset_n = 1'b0;
      #1;
      check("t7_busy", busy, 0);
      check("t7_hold", core_hold, 0);
      check("t7_strobes", {mgmt.mgmt_write, mgmt.mgmt_read}, 0);
      check("t7_addr", mgmt.mgmt_address, 0);
      check("t7_active", active_profile, 0);
      check("t7_state", dbg_state, ST_IDLE);
      exp_q.delete();
      lock_timer = -1;
      repeat (2) @(negedge clk_sys);
      #1 reset_n = 1'b1;

`ifdef PLL_RECONFIG_READBACK_EN
      // Corrupted C1 readback
      corrupt_c1 = 1'b1;
      start_seq(1, 1, 40, 0, 4, 0, 0);
      wait_idle();
      corrupt_c1 = 1'b0;
      check("t8_error", error, 1);
      check("t8_active", active_profile, 0);
      check("t8_q_empty", exp_q.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
